pe_conv_ctrl: RTL and testbench
===============================

// Module: pe_conv_ctrl
// PURPOSE
//  Sequencer for one PE's 1-D row convolution: drives filter/ifmap scratchpad
//  addresses, the MAC enable, and the clear/enable of the psum accumulator DFF.
//  Computes E = W-S+1 outputs, each an S-tap dot product.
//  Each finished psum goes out on a valid/ready handshake. Sits between the
//  array-level scheduler (start/done) and the PE datapath.
// PARAMETERS
//  S_W    4  width of cfg_s (filter length, 1..2^S_W-1)
//  W_W    6  width of cfg_w (ifmap row length, 1..2^W_W-1); also ifmap_addr/out_idx width
// PORTS
//  clk         in   1    clock, all state on rising edge
//  rst         in   1    synchronous reset, active high
//  start       in   1    begin a row; sampled only in IDLE
//  cfg_s       in   S_W  filter length S, latched on accepted start
//  cfg_w       in   W_W  ifmap length W, latched on accepted start
//  busy        out  1    high in every state except IDLE
//  done        out  1    one-cycle pulse when the row finishes or is rejected
//  err         out  1    valid with done: 1 = illegal config, no MACs issued
//  filt_addr   out  S_W  filter spad read address k
//  ifmap_addr  out  W_W  ifmap spad read address e+k
//  mac_en      out  1    MAC issue strobe; addresses valid when high
//  psum_clr    out  1    with mac_en: accumulator loads product, not sum
//  out_valid   out  1    psum for out_idx is ready in accumulator
//  out_ready   in   1    consumer accepts psum (handshake when both high)
//  out_idx     out  W_W  output index e of the presented psum
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Latched cfg and counters e,k = 0.
//  rst wins over every other input in the same cycle, incl. mid-row.
//  States:
//  - IDLE: start=1 latches cfg.
//    - If S==0 or S>W: go to DONE with err set.
//    - Otherwise go to MAC with e=0, k=0.
//  - MAC: mac_en=1, filt_addr=k, ifmap_addr=e+k, psum_clr=(k==0).
//    - k increments each cycle.
//    - At k==S-1: go to WAIT.
//  - WAIT: one bubble while the accumulator DFF captures the last product.
//    No strobes. Go to OUT.
//  - OUT: out_valid=1, out_idx=e. Hold until out_ready=1.
//    - On handshake with e==E-1: go to DONE.
//    - Else: e+1, k=0, go to MAC.
//    out_valid stays high and out_idx stays stable while out_ready=0.
//  - DONE: done=1 for exactly one cycle; err=1 iff config was rejected.
//    Go to IDLE.
//  Timing, no backpressure:
//  - Per output: S MAC cycles + 1 WAIT + 1 OUT.
//  - start accepted at cycle 0. First mac_en at cycle 1.
//  - done at cycle 1 + E*(S+2).
//  - Illegal config: done=err=1 at cycle 1.
//  Arithmetic:
//  - E = W-S+1, computed in W_W bits (no overflow for legal configs).
//  - e+k <= W-1 always; no wrap-around.
//  start while busy is ignored. cfg_* is don't-care outside accepted start.
//  start in the DONE cycle is ignored. start is accepted in the next cycle,
//  which is IDLE, so back-to-back rows lose one cycle.
//  busy=1 in MAC/WAIT/OUT/DONE. err holds 0 except during a DONE caused by reject.
// TESTING
//  1. S=3,W=5, out_ready=1:
//     - mac_en in cycles 1-3, 6-8, 11-13.
//     - ifmap_addr 0,1,2 | 1,2,3 | 2,3,4; filt_addr 0,1,2 repeated.
//     - psum_clr at cycles 1,6,11.
//     - out_valid at 5,10,15 with out_idx 0,1,2.
//     - done at 16, err=0.
//  2. Same config, out_ready low 4 cycles at each out_valid:
//     - out_valid/out_idx held stable, no mac_en while waiting.
//     - done at 16+12=28.
//  3. S=4,W=4: exactly 4 MACs, one out_valid (out_idx=0), done at cycle 7.
//  4. Illegal configs:
//     - S=0,W=8 -> done=err=1 at cycle 1, no mac_en, no out_valid.
//     - S=6,W=5 -> same.
//  5. rst pulsed during 2nd MAC of output 1 (S=3,W=5):
//     - next cycle all outputs 0, IDLE.
//     - New start S=2,W=3 runs cleanly: 2 outputs, done at cycle 9.
//  6. start held high through busy and DONE:
//     - Ignored until IDLE.
//     - Second row's first mac_en exactly 2 cycles after the done pulse.
//     - cfg_* changes mid-row have no effect.

Source files
------------

// File: rtl/pe_conv_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_conv_ctrl_if                                                          |
// | Scheduler, datapath and psum-consumer signals of one PE row sequencer.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pe_conv_ctrl_if #(
  parameter int S_W = 4,
  parameter int W_W = 6
);
  logic           start;
  logic [S_W-1:0] cfg_s;
  logic [W_W-1:0] cfg_w;
  logic           busy;
  logic           done;
  logic           err;
  logic [S_W-1:0] filt_addr;
  logic [W_W-1:0] ifmap_addr;
  logic           mac_en;
  logic           psum_clr;
  logic           out_valid;
  logic           out_ready;
  logic [W_W-1:0] out_idx;

  modport master (
    output start, cfg_s, cfg_w, out_ready,
    input  busy, done, err, filt_addr, ifmap_addr, mac_en, psum_clr,
           out_valid, out_idx
  );

  modport slave (
    input  start, cfg_s, cfg_w, out_ready,
    output busy, done, err, filt_addr, ifmap_addr, mac_en, psum_clr,
           out_valid, out_idx
  );
endinterface
`default_nettype wire

// File: rtl/pe_conv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_conv_ctrl                                                             |
// | Sequences a 1-D row convolution: E=W-S+1 outputs of S MACs each.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pe_conv_ctrl #(
  parameter int S_W = 4,
  parameter int W_W = 6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pe_conv_ctrl_if.slave      bus
);

  localparam int CW = (S_W > W_W) ? S_W : W_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MAC  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]     r_state;
  logic [2:0]     w_next_state;
  logic [S_W-1:0] r_k;
  logic [S_W-1:0] r_k_last;
  logic [W_W-1:0] r_e;
  logic [W_W-1:0] r_e_last;
  logic           r_rej;

  logic [CW-1:0]  w_s_ext;
  logic [CW-1:0]  w_w_ext;
  logic [CW-1:0]  w_span;
  logic [CW-1:0]  w_addr;
  logic           w_cfg_bad;
  logic           w_k_last;
  logic           w_e_last;
  logic           w_handshake;

  assign w_s_ext     = CW'(bus.cfg_s);
  assign w_w_ext     = CW'(bus.cfg_w);
  assign w_cfg_bad   = (bus.cfg_s == '0) || (w_s_ext > w_w_ext);
  // W-S equals E-1; only meaningful when the config is accepted
  assign w_span      = w_w_ext - w_s_ext;
  assign w_addr      = CW'(r_e) + CW'(r_k);
  assign w_k_last    = (r_k == r_k_last);
  assign w_e_last    = (r_e == r_e_last);
  assign w_handshake = bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next_state = w_cfg_bad ? ST_DONE : ST_MAC;
      ST_MAC:  if (w_k_last)  w_next_state = ST_WAIT;
      ST_WAIT: w_next_state = ST_OUT;
      ST_OUT:  if (w_handshake) w_next_state = w_e_last ? ST_DONE : ST_MAC;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_k_last <= '0;
      r_e      <= '0;
      r_e_last <= '0;
      r_rej    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_k_last <= bus.cfg_s - S_W'(1);
            r_e_last <= w_span[W_W-1:0];
            r_rej    <= w_cfg_bad;
            r_e      <= '0;
            r_k      <= '0;
          end
        end
        ST_MAC: r_k <= r_k + S_W'(1);
        ST_OUT: begin
          if (w_handshake && !w_e_last) begin
            r_e <= r_e + W_W'(1);
            r_k <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (r_state != ST_IDLE);
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    bus.mac_en     = 1'b0;
    bus.psum_clr   = 1'b0;
    bus.filt_addr  = '0;
    bus.ifmap_addr = '0;
    bus.out_valid  = 1'b0;
    bus.out_idx    = '0;
    case (r_state)
      ST_MAC: begin
        bus.mac_en     = 1'b1;
        bus.psum_clr   = (r_k == '0);
        bus.filt_addr  = r_k;
        bus.ifmap_addr = w_addr[W_W-1:0];
      end
      ST_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = r_e;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        bus.err  = r_rej;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_conv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pe_conv_ctrl                                                          |
// | Scoreboard bench: stimulus queues expected events, monitor pops them.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pe_conv_ctrl;

  typedef struct {
    int kind;   // 0 = mac, 1 = out handshake, 2 = done
    int a;
    int b;
    int c;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   gap = 0;
  int   wcnt = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   first_mac_cyc = 0;
  bit   arm_mac = 1'b0;
  exp_t q[$];
  exp_t mx;

  pe_conv_ctrl_if #(.S_W(4), .W_W(6)) bus ();

  pe_conv_ctrl #(.S_W(4), .W_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected DUT event at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline of one row as seen from the start-accept cycle t0
  task automatic push_row(input int s, input int w, input int g, input int t0);
    exp_t x;
    int   t;
    if (s == 0 || s > w) begin
      x = '{2, 1, 0, 0, t0 + 1};
      q.push_back(x);
    end else begin
      t = t0 + 1;
      for (int e = 0; e <= w - s; e++) begin
        for (int k = 0; k < s; k++) begin
          x = '{0, k, e + k, (k == 0) ? 1 : 0, t};
          q.push_back(x);
          t++;
        end
        t = t + 1 + g;
        x = '{1, e, 0, 0, t};
        q.push_back(x);
        t++;
      end
      x = '{2, 0, 0, 0, t};
      q.push_back(x);
    end
  endtask

  task automatic start_row(input int s, input int w, output int t0);
    tick();
    t0 = cyc;
    bus.cfg_s = 4'(s);
    bus.cfg_w = 6'(w);
    bus.start = 1'b1;
    push_row(s, w, gap, t0);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int exp_rel, input string name);
    int n0;
    int i;
    n0 = done_cnt;
    i = 0;
    while (done_cnt == n0 && i < 400) begin
      @(posedge clk);
      i++;
    end
    chk({name, "_seen"}, done_cnt - n0, 1);
    chk({name, "_rel_cycle"}, last_done_cyc - t0, exp_rel);
  endtask

  task automatic chk_idle(input string name);
    chk(name, int'({bus.busy, bus.done, bus.err, bus.mac_en, bus.psum_clr,
                    bus.out_valid, bus.filt_addr, bus.ifmap_addr, bus.out_idx}), 0);
  endtask

  // Consumer: holds out_ready low for 'gap' cycles of each out_valid
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      tick();
      if (bus.out_valid && wcnt < gap) begin
        bus.out_ready = 1'b0;
        wcnt++;
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mac_en) begin
        if (arm_mac) begin
          first_mac_cyc = cyc;
          arm_mac = 1'b0;
        end
        if (q.size() == 0 || q[0].kind != 0) unexpected("mac_en");
        else begin
          mx = q.pop_front();
          chk("mac_cycle", cyc, mx.cyc);
          chk("filt_addr", int'(bus.filt_addr), mx.a);
          chk("ifmap_addr", int'(bus.ifmap_addr), mx.b);
          chk("psum_clr", int'(bus.psum_clr), mx.c);
          chk("mac_busy", int'(bus.busy), 1);
        end
      end
      if (bus.out_valid) begin
        if (q.size() == 0 || q[0].kind != 1) unexpected("out_valid");
        else if (bus.out_ready) begin
          mx = q.pop_front();
          chk("out_cycle", cyc, mx.cyc);
          chk("out_idx", int'(bus.out_idx), mx.a);
        end else begin
          chk("out_idx_hold", int'(bus.out_idx), q[0].a);
        end
      end
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
        arm_mac = 1'b1;
        if (q.size() == 0 || q[0].kind != 2) unexpected("done");
        else begin
          mx = q.pop_front();
          chk("done_cycle", cyc, mx.cyc);
          chk("done_err", int'(bus.err), mx.a);
          chk("done_busy", int'(bus.busy), 1);
        end
      end else if (bus.err) begin
        unexpected("err_outside_done");
      end
    end
  end

  initial begin
    int t0;
    int t1;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_s = '0;
    bus.cfg_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset_outputs");
    tick();
    rst = 1'b0;

    // 1: S=3 W=5, no backpressure
    start_row(3, 5, t0);
    wait_done(t0, 16, "row_s3w5");

    // 2: same, consumer stalls 4 cycles per output
    gap = 4;
    start_row(3, 5, t0);
    wait_done(t0, 28, "row_s3w5_bp");
    gap = 0;

    // 3: S=W, single output
    start_row(4, 4, t0);
    wait_done(t0, 7, "row_s4w4");

    // 4: illegal configs
    start_row(0, 8, t0);
    wait_done(t0, 1, "rej_s0");
    start_row(6, 5, t0);
    wait_done(t0, 1, "rej_s6w5");

    // 5: reset during 2nd MAC of output 1, then a clean row
    start_row(3, 5, t0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk_idle("midrow_reset_outputs");
    start_row(2, 3, t0);
    wait_done(t0, 9, "row_after_rst");

    // 6: start held through the row and DONE; cfg changes mid-row
    tick();
    t0 = cyc;
    bus.cfg_s = 4'd3;
    bus.cfg_w = 6'd5;
    bus.start = 1'b1;
    push_row(3, 5, 0, t0);
    repeat (3) tick();
    bus.cfg_s = 4'd2;
    bus.cfg_w = 6'd3;
    repeat (14) tick();
    t1 = cyc;
    push_row(2, 3, 0, t1);
    tick();
    bus.start = 1'b0;
    wait_done(t1, 9, "held_start_row2");
    chk("held_start_row2_offset", t1 - t0, 17);
    chk("mac_after_done_gap", first_mac_cyc - (t0 + 16), 2);

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
